// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg
// Shared constants and types for the double-buffered VGA framebuffer.
//   H_ACTIVE, V_ACTIVE : default visible raster size
//   FB_PIXELS          : pixels per bank
//   fb_state_t         : write-side state machine encoding
package vga_fb_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        FB_CLEAR,
        FB_DRAW,
        FB_WAIT_SWAP
    } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen
// Combinational raster position to linear framebuffer address.
//   row  : visible row
//   col  : visible column
//   addr : row*H_ACTIVE+col, truncated to ADDR_W
module fb_addr_gen #(
    parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
    parameter int ADDR_W   = 19
) (
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    output logic [ADDR_W-1:0] addr
);

    generate
        if (H_ACTIVE == 640) begin : g_shift_add
            // 640 = 512 + 128, so two shifts and adds replace the multiplier
            assign addr = (ADDR_W'(row) << 9) + (ADDR_W'(row) << 7) + ADDR_W'(col);
        end else begin : g_generic
            assign addr = ADDR_W'(row) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);
        end
    endgenerate

endmodule

// File: rtl/m_counter.sv
// m_counter
// Generic up-counter with synchronous clear, load and enable.
//   clk      : clock
//   clr      : synchronous clear to zero (highest priority)
//   load     : load load_val
//   load_val : value loaded when load is high
//   en       : increment by one
//   q        : current count
module m_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Arbitrates one single-port synchronous framebuffer RAM between display
// scan-out (highest), the back-bank clear engine, and the draw engine.
// Swaps front/back banks in vertical blank once a frame is complete.
//   clk, rst              : clock, synchronous active-high reset
//   rd_req, row, col      : display pixel request and raster position
//   vblank                : high outside visible rows
//   rd_valid, rd_pixel    : front-bank pixel, one cycle after rd_req
//   wr_valid/addr/data    : draw engine write into the back bank
//   wr_ready              : write accepted when wr_valid & wr_ready
//   frame_done            : back bank fully drawn (pulse)
//   front_bank            : bank currently displayed
//   swap_pending, clearing: state indications
//   mem_*                 : RAM port, address is {bank, linear address}
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int PIX_W    = 4,
    parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_fb_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    input  logic              vblank,
    output logic              rd_valid,
    output logic [PIX_W-1:0]  rd_pixel,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              frame_done,
    output logic              front_bank,
    output logic              swap_pending,
    output logic              clearing,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    localparam int                FB_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    fb_state_t         state_reg;
    fb_state_t         state_next;
    logic              front_bank_reg;
    logic              rd_valid_reg;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_en;
    logic              swap;

    fb_addr_gen #(
        .H_ACTIVE(H_ACTIVE),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .row (row),
        .col (col),
        .addr(disp_addr)
    );

    // Count holds at the terminal address instead of wrapping.
    m_counter #(
        .W(ADDR_W)
    ) u_clr_cnt (
        .clk     (clk),
        .clr     (rst),
        .load    (swap),
        .load_val('0),
        .en      (clr_en),
        .q       (clr_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FB_CLEAR;
            front_bank_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= rd_req;
            if (swap) begin
                front_bank_reg <= ~front_bank_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        wr_ready   = 1'b0;
        clr_en     = 1'b0;
        swap       = 1'b0;

        // Display read owns the RAM whenever it asks; other users stall.
        if (rd_req) begin
            mem_addr = {front_bank_reg, disp_addr};
        end

        case (state_reg)
            FB_CLEAR: begin
                if (!rd_req) begin
                    mem_addr = {~front_bank_reg, clr_cnt};
                    mem_we   = 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state_next = FB_DRAW;
                    end else begin
                        clr_en = 1'b1;
                    end
                end
            end
            FB_DRAW: begin
                wr_ready = ~rd_req;
                // Out-of-range addresses are accepted but never reach the RAM.
                if (wr_valid && !rd_req && (wr_addr <= LAST_ADDR)) begin
                    mem_addr  = {~front_bank_reg, wr_addr};
                    mem_we    = 1'b1;
                    mem_wdata = wr_data;
                end
                if (frame_done) begin
                    state_next = FB_WAIT_SWAP;
                end
            end
            FB_WAIT_SWAP: begin
                if (vblank && !rd_req) begin
                    swap       = 1'b1;
                    state_next = FB_CLEAR;
                end
            end
            default: begin
                state_next = FB_CLEAR;
            end
        endcase
    end

    assign rd_valid     = rd_valid_reg;
    assign rd_pixel     = rd_valid_reg ? mem_rdata : '0;
    assign front_bank   = front_bank_reg;
    assign swap_pending = (state_reg == FB_WAIT_SWAP);
    assign clearing     = (state_reg == FB_CLEAR);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int PIX_W = 4;
    localparam int H     = 640;
    localparam int V     = 8;
    localparam int AW    = 13;
    localparam int FB    = H * V;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [8:0]        row;
    logic [9:0]        col;
    logic              vblank;
    logic              rd_valid;
    logic [PIX_W-1:0]  rd_pixel;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_ready;
    logic              frame_done;
    logic              front_bank;
    logic              swap_pending;
    logic              clearing;
    logic [AW:0]       mem_addr;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    vga_fb_arbiter #(
        .PIX_W   (PIX_W),
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .row         (row),
        .col         (col),
        .vblank      (vblank),
        .rd_valid    (rd_valid),
        .rd_pixel    (rd_pixel),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_done  (frame_done),
        .front_bank  (front_bank),
        .swap_pending(swap_pending),
        .clearing    (clearing),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [PIX_W-1:0] exp_q[$];

    typedef struct {
        logic [8:0] row;
        logic [9:0] col;
        int         addr;
    } rd_vec_t;

    rd_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock. RAM read data for this edge is chosen here; when a
    // read was issued the chosen pixel is the scoreboard's expected rd_pixel.
    task automatic cycle(input int px_force = -1);
        logic             was_rd;
        logic             was_rst;
        logic [PIX_W-1:0] px;
        was_rd  = rd_req;
        was_rst = rst;
        @(posedge clk);
        #1;
        px = (px_force >= 0) ? PIX_W'(px_force) : PIX_W'($urandom);
        mem_rdata = px;
        if (was_rd && !was_rst) exp_q.push_back(px);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(was_rd & ~was_rst));
        if (exp_q.size() > 0) chk("rd_pixel", 32'(rd_pixel), 32'(exp_q.pop_front()));
        else                  chk("rd_pixel_idle", 32'(rd_pixel), 32'(0));
    endtask

    task automatic run_clear(input logic bank, input int from);
        for (int i = from; i < FB; i++) begin
            if (i == from + 10) begin
                // frame_done outside drawing must be ignored
                frame_done = 1'b1;
            end
            if (i == from + 50) begin
                // display read stalls the clear without losing a count
                rd_req = 1'b1;
                #5;
                chk("stall_we", 32'(mem_we), 32'(0));
                chk("stall_addr", 32'(mem_addr), 32'({~bank, AW'(2 * H + 5)}));
                cycle();
                rd_req = 1'b0;
            end
            #5;
            chk("clr_we", 32'(mem_we), 32'(1));
            chk("clr_addr", 32'(mem_addr), 32'({bank, AW'(i)}));
            chk("clr_wdata", 32'(mem_wdata), 32'(0));
            chk("clr_ready", 32'(wr_ready), 32'(0));
            chk("clearing", 32'(clearing), 32'(1));
            cycle();
            frame_done = 1'b0;
        end
        #5;
        chk("clr_end_clearing", 32'(clearing), 32'(0));
        chk("clr_end_ready", 32'(wr_ready), 32'(1));
        $display("clear bank %0d from %0d finished, clearing=%0b wr_ready=%0b", bank, from, clearing, wr_ready);
    endtask

    initial begin
        vecs[0] = '{row: 9'd2, col: 10'd5,   addr: 1285};
        vecs[1] = '{row: 9'd0, col: 10'd0,   addr: 0};
        vecs[2] = '{row: 9'd7, col: 10'd639, addr: 7 * 640 + 639};
        vecs[3] = '{row: 9'd1, col: 10'd0,   addr: 640};
        vecs[4] = '{row: 9'd3, col: 10'd100, addr: 2020};
        vecs[5] = '{row: 9'd5, col: 10'd17,  addr: 3217};

        rst = 1'b1; rd_req = 1'b0; row = 9'd2; col = 10'd5; vblank = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; frame_done = 1'b0; mem_rdata = '0;

        // Reset
        repeat (3) cycle();
        chk("rst_clearing", 32'(clearing), 32'(1));
        chk("rst_swap_pending", 32'(swap_pending), 32'(0));
        chk("rst_front_bank", 32'(front_bank), 32'(0));
        $display("reset: clearing=%0b swap_pending=%0b front_bank=%0b", clearing, swap_pending, front_bank);
        rst = 1'b0;

        // Clear fills bank 1
        run_clear(1'b1, 0);

        // Draw: read blocks the write, then the write goes through
        rd_req = 1'b1; wr_valid = 1'b1; wr_addr = AW'(1234); wr_data = 4'hA;
        #5;
        chk("blk_ready", 32'(wr_ready), 32'(0));
        chk("blk_we", 32'(mem_we), 32'(0));
        chk("blk_addr", 32'(mem_addr), 32'({1'b0, AW'(1285)}));
        cycle();
        rd_req = 1'b0;
        #5;
        chk("wr_ready", 32'(wr_ready), 32'(1));
        chk("wr_we", 32'(mem_we), 32'(1));
        chk("wr_addr", 32'(mem_addr), 32'({1'b1, AW'(1234)}));
        chk("wr_data", 32'(mem_wdata), 32'(4'hA));
        $display("write 1234: mem_addr=0x%0h we=%0b data=0x%0h", mem_addr, mem_we, mem_wdata);
        cycle();
        wr_valid = 1'b0;
        #5;
        chk("idle_we", 32'(mem_we), 32'(0));
        chk("idle_addr", 32'(mem_addr), 32'(0));
        cycle();

        // Table of display reads, with a competing write held off
        for (int v = 0; v < 6; v++) begin
            row = vecs[v].row; col = vecs[v].col;
            rd_req = 1'b1; wr_valid = 1'b1; wr_addr = AW'(v);
            #5;
            chk("vec_addr", 32'(mem_addr), 32'({1'b0, AW'(vecs[v].addr)}));
            chk("vec_we", 32'(mem_we), 32'(0));
            chk("vec_ready", 32'(wr_ready), 32'(0));
            $display("read row=%0d col=%0d mem_addr=0x%0h expect 0x%0h", row, col, mem_addr, vecs[v].addr);
            cycle(v == 0 ? 7 : -1);
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        row = 9'd2; col = 10'd5;
        cycle();

        // Out-of-range write is accepted and dropped
        wr_valid = 1'b1; wr_addr = AW'(FB);
        #5;
        chk("oor_ready", 32'(wr_ready), 32'(1));
        chk("oor_we", 32'(mem_we), 32'(0));
        chk("oor_addr", 32'(mem_addr), 32'(0));
        $display("write %0d (out of range): wr_ready=%0b we=%0b", FB, wr_ready, mem_we);
        cycle();

        // frame_done with a same-cycle write, vblank low
        wr_addr = AW'(10); wr_data = 4'h3; frame_done = 1'b1;
        #5;
        chk("fd_we", 32'(mem_we), 32'(1));
        chk("fd_addr", 32'(mem_addr), 32'({1'b1, AW'(10)}));
        cycle();
        frame_done = 1'b0;
        #5;
        chk("wait_pending", 32'(swap_pending), 32'(1));
        chk("wait_ready", 32'(wr_ready), 32'(0));
        chk("wait_we", 32'(mem_we), 32'(0));
        cycle();
        wr_valid = 1'b0;
        cycle();
        chk("no_swap_vb0", 32'(front_bank), 32'(0));
        vblank = 1'b1; rd_req = 1'b1;
        #5;
        chk("wait_rd_addr", 32'(mem_addr), 32'({1'b0, AW'(1285)}));
        cycle();
        chk("no_swap_rd", 32'(front_bank), 32'(0));
        chk("still_pending", 32'(swap_pending), 32'(1));
        rd_req = 1'b0;
        #5;
        chk("swap_cycle_we", 32'(mem_we), 32'(0));
        cycle();
        vblank = 1'b0;
        chk("swap_front", 32'(front_bank), 32'(1));
        chk("swap_clearing", 32'(clearing), 32'(1));
        chk("swap_pending_clr", 32'(swap_pending), 32'(0));
        $display("swap: front_bank=%0b clearing=%0b", front_bank, clearing);

        // Clear now targets bank 0; stall read uses the new front bank 1
        run_clear(1'b0, 0);

        // Reset mid-draw with a read in flight
        rd_req = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0; rd_req = 1'b0;
        chk("mrst_front", 32'(front_bank), 32'(0));
        chk("mrst_clearing", 32'(clearing), 32'(1));
        chk("mrst_pending", 32'(swap_pending), 32'(0));
        #5;
        chk("mrst_addr0", 32'(mem_addr), 32'({1'b1, AW'(0)}));
        chk("mrst_we", 32'(mem_we), 32'(1));
        cycle();
        #5;
        chk("mrst_addr1", 32'(mem_addr), 32'({1'b1, AW'(1)}));
        $display("reset mid-draw: front_bank=%0b clearing=%0b mem_addr=0x%0h", front_bank, clearing, mem_addr);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
